// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU among NREQ valid/ready requesters.
// Optional saturating per-requester grant counters: define ALU_SHARE_ARB_GRANT_CNT_EN.
module alu_share_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 64,
  parameter int IDW   = $clog2(NREQ)
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [1:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  busy
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [IDW-1:0] last_grant_r;
  logic [IDW-1:0] grant_id_r;
  logic [IDW-1:0] grant_idx_s;
  logic           grant_found_s;
  logic           grant_en_s;
  logic [IDW:0]   cand_s;

  // Round-robin pick: first valid requester after the last one granted, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = {1'b0, last_grant_r} + (IDW+1)'(k);
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grant qualification, request accept and next-state decode.
  always_comb begin
    grant_en_s  = 1'b0;
    state_nxt_s = state_r;
    req_ready   = '0;
    case (state_r)
      IDLE: begin
        grant_en_s = grant_found_s;
        if (grant_found_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        // A new grant is allowed only in the cycle the held response is taken.
        grant_en_s = grant_found_s & rsp_ready;
        if (!rsp_ready) begin
          state_nxt_s = RESP;
        end else if (grant_found_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (grant_en_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // State, operand registers toward the ALU and the captured response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDW'(NREQ-1);
      grant_id_r   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_flags    <= 4'b0000;
      busy         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      if (grant_en_s) begin
        alu_a        <= req_a[int'(grant_idx_s)*WIDTH +: WIDTH];
        alu_b        <= req_b[int'(grant_idx_s)*WIDTH +: WIDTH];
        alu_ctrl     <= req_ctrl[int'(grant_idx_s)*2 +: 2];
        grant_id_r   <= grant_idx_s;
        last_grant_r <= grant_idx_s;
      end
      if (state_r == ISSUE) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= grant_id_r;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  // Saturating accept counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_clr) begin
          grant_cnt[i*CNT_W +: CNT_W] <= '0;
        end else if (req_valid[i] && req_ready[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin pointer, one outstanding op, ALU arithmetic).
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int NREQ  = 3;
  localparam int WIDTH = 64;
  localparam int IDW   = 2;
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*2-1:0]     req_ctrl = '0;
  logic [WIDTH-1:0]      alu_a, alu_b, alu_result;
  logic [1:0]            alu_ctrl;
  logic [3:0]            alu_flags;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic [3:0]            rsp_flags;
  logic                  busy;
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  logic                  cnt_clr = 1'b0;
  logic [NREQ*CNT_W-1:0] grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH)
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt)
`endif
  );

  // Reference ALU: returns {neg, zero, carry, overflow, result}.
  function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic [64:0] s;
    logic [63:0] r;
    logic        c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[63:0]; c = s[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 65'd1;
        r = s[63:0]; c = s[64];
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[63], (r == 64'd0), c, v, r};
  endfunction

  assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    #3;
    n_tests++;
    if ({alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_flags, busy, req_ready} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got rsp_valid=%b busy=%b alu_a=%h rsp_result=%h, expected all zero", rsp_valid, busy, alu_a, rsp_result); end
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    n_tests++;
    if ({req_ready, busy, rsp_valid} !== 5'b0)
      begin n_fail++; $display("FAIL reset_idle: got req_ready=%b busy=%b rsp_valid=%b, expected 0", req_ready, busy, rsp_valid); end
  endtask

  task automatic test_directed();
    int              ti [3];
    logic [63:0]     ta [3];
    logic [63:0]     tb [3];
    logic [1:0]      tc [3];
    logic [63:0]     tr [3];
    logic [3:0]      tf [3];
    logic [NREQ-1:0] exp_rdy;
    ti = '{0, 1, 2};
    ta = '{64'd5, 64'd3, 64'h7FFF_FFFF_FFFF_FFFF};
    tb = '{64'd3, 64'd5, 64'd1};
    tc = '{2'b01, 2'b01, 2'b00};
    tr = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000};
    tf = '{4'b0010, 4'b1000, 4'b1001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_a[ti[i]*WIDTH +: WIDTH] = ta[i];
      req_b[ti[i]*WIDTH +: WIDTH] = tb[i];
      req_ctrl[ti[i]*2 +: 2]      = tc[i];
      req_valid = '0; req_valid[ti[i]] = 1'b1; rsp_ready = 1'b1;
      exp_rdy = '0; exp_rdy[ti[i]] = 1'b1;
      #2;
      n_tests++;
      if (req_ready !== exp_rdy)
        begin n_fail++; $display("FAIL dir_grant[%0d]: got req_ready=%b expected %b", i, req_ready, exp_rdy); end
      @(negedge clk);
      req_valid = '0;
      #2;
      n_tests++;
      if (rsp_valid !== 1'b0)
        begin n_fail++; $display("FAIL dir_early[%0d]: got rsp_valid=%b expected 0", i, rsp_valid); end
      @(negedge clk);
      #2;
      n_tests++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, IDW'(ti[i]), tr[i], tf[i]})
        begin n_fail++; $display("FAIL dir_rsp[%0d]: got v=%b id=%0d res=%h flags=%b expected v=1 id=%0d res=%h flags=%b",
                                 i, rsp_valid, rsp_id, rsp_result, rsp_flags, ti[i], tr[i], tf[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_all_valid();
    int              order [5];
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv;
    order = '{0, 1, 2, 0, 1};
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = rand_opnd();
      req_b[i*WIDTH +: WIDTH] = rand_opnd();
      req_ctrl[i*2 +: 2]      = 2'($urandom_range(0, 3));
    end
    req_valid = '1; rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      exp_rdy = ((c % 2) == 0) ? (3'b001 << order[c/2]) : 3'b000;
      exp_rv  = (c >= 2) && ((c % 2) == 0);
      n_tests++;
      if (req_ready !== exp_rdy)
        begin n_fail++; $display("FAIL rr_grant[c%0d]: got req_ready=%b expected %b", c, req_ready, exp_rdy); end
      n_tests++;
      if (rsp_valid !== exp_rv || (exp_rv && rsp_id !== IDW'(order[c/2-1])))
        begin n_fail++; $display("FAIL rr_rsp[c%0d]: got v=%b id=%0d expected v=%b", c, rsp_valid, rsp_id, exp_rv); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [67:0] exp1, exp2;
    req_a[0 +: WIDTH] = rand_opnd(); req_b[0 +: WIDTH] = rand_opnd(); req_ctrl[1:0] = 2'b01;
    exp1 = alu_model(req_a[0 +: WIDTH], req_b[0 +: WIDTH], 2'b01);
    req_valid = 3'b001; rsp_ready = 1'b0;
    #2;
    n_tests++;
    if (req_ready !== 3'b001)
      begin n_fail++; $display("FAIL bp_grant1: got req_ready=%b expected 001", req_ready); end
    @(negedge clk);
    req_a[0 +: WIDTH] = rand_opnd(); req_b[0 +: WIDTH] = rand_opnd(); req_ctrl[1:0] = 2'b00;
    exp2 = alu_model(req_a[0 +: WIDTH], req_b[0 +: WIDTH], 2'b00);
    #2;
    n_tests++;
    if (req_ready !== 3'b000)
      begin n_fail++; $display("FAIL bp_issue_ready: got req_ready=%b expected 000", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      n_tests++;
      if ({req_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_result} !== {3'b000, 1'b1, 1'b1, 2'd0, exp1})
        begin n_fail++; $display("FAIL bp_hold[c%0d]: got rdy=%b busy=%b v=%b id=%0d flags=%b res=%h expected rdy=000 busy=1 v=1 id=0 res=%h",
                                 c, req_ready, busy, rsp_valid, rsp_id, rsp_flags, rsp_result, exp1[63:0]); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #2;
    n_tests++;
    if (req_ready !== 3'b001 || rsp_valid !== 1'b1)
      begin n_fail++; $display("FAIL bp_release: got req_ready=%b rsp_valid=%b expected 001/1", req_ready, rsp_valid); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2;
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_flags, rsp_result} !== {1'b1, 2'd0, exp2})
      begin n_fail++; $display("FAIL bp_rsp2: got v=%b id=%0d res=%h expected v=1 id=0 res=%h", rsp_valid, rsp_id, rsp_result, exp2[63:0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    req_a[1*WIDTH +: WIDTH] = 64'h1234_5678_9ABC_DEF0;
    req_b[1*WIDTH +: WIDTH] = 64'h0FF0_0FF0_0FF0_0FF0;
    req_ctrl[3:2] = 2'b10;
    req_valid = 3'b010; rsp_ready = 1'b1;
    #2;
    n_tests++;
    if (req_ready !== 3'b010)
      begin n_fail++; $display("FAIL mid_grant: got req_ready=%b expected 010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_flags, busy, req_ready} !== '0)
      begin n_fail++; $display("FAIL mid_reset_outputs: got busy=%b alu_a=%h alu_ctrl=%b rsp_valid=%b, expected all zero", busy, alu_a, alu_ctrl, rsp_valid); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL mid_no_rsp[c%0d]: got rsp_valid=%b busy=%b expected 0/0", c, rsp_valid, busy); end
      @(negedge clk);
    end
    req_valid = 3'b011;
    #2;
    n_tests++;
    if (req_ready !== 3'b001)
      begin n_fail++; $display("FAIL mid_first_grant: got req_ready=%b expected 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    int exp_c;
    apply_reset();
    rsp_ready = 1'b1;
    req_a[0 +: WIDTH] = 64'd1; req_b[0 +: WIDTH] = 64'd1; req_ctrl[1:0] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      req_valid = 3'b001;
      @(negedge clk);
      req_valid = '0;
      #2;
      exp_c = (i + 1 > 3) ? 3 : i + 1;
      n_tests++;
      if (grant_cnt !== {2'd0, 2'd0, 2'(exp_c)})
        begin n_fail++; $display("FAIL cnt_sat[%0d]: got grant_cnt=%h expected count0=%0d", i, grant_cnt, exp_c); end
      repeat (2) @(negedge clk);
    end
    cnt_clr = 1'b1; req_valid = 3'b001;
    #2;
    n_tests++;
    if (req_ready !== 3'b001)
      begin n_fail++; $display("FAIL cnt_clr_grant: got req_ready=%b expected 001", req_ready); end
    @(negedge clk);
    cnt_clr = 1'b0; req_valid = '0;
    #2;
    n_tests++;
    if (grant_cnt !== '0)
      begin n_fail++; $display("FAIL cnt_clr: got grant_cnt=%h expected 0", grant_cnt); end
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] acc, exp_rdy;
    logic            outst, free, draining, found;
    logic [IDW-1:0]  exp_id;
    logic [67:0]     exp_v;
    int              last, acc_cyc, cyc, g;
    apply_reset();
    acc = '0; outst = 1'b0; last = NREQ - 1; acc_cyc = 0; cyc = 0; exp_id = '0; exp_v = '0;
    for (int t = 0; t < 800; t++) begin
      draining = (t >= 600);
      if (t > 0) @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          if (!draining && $urandom_range(0, 2) != 0) begin
            req_a[i*WIDTH +: WIDTH] = rand_opnd();
            req_b[i*WIDTH +: WIDTH] = rand_opnd();
            req_ctrl[i*2 +: 2]      = 2'($urandom_range(0, 3));
            req_valid[i] = 1'b1;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      acc = '0;
      rsp_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (draining && !outst && req_valid == '0) break;
      #2;
      cyc++;
      n_tests++;
      if (busy !== outst)
        begin n_fail++; $display("FAIL rnd_busy[cyc%0d]: got busy=%b expected %b", cyc, busy, outst); end
      free = !outst || (rsp_valid && rsp_ready);
      if (rsp_valid) begin
        n_tests++;
        if (!outst || cyc < acc_cyc + 2) begin
          n_fail++; $display("FAIL rnd_spurious[cyc%0d]: got rsp_valid=1 expected 0 (outstanding=%b accepted at %0d)", cyc, outst, acc_cyc);
        end else if (rsp_ready) begin
          if ({rsp_id, rsp_flags, rsp_result} !== {exp_id, exp_v})
            begin n_fail++; $display("FAIL rnd_rsp[cyc%0d]: got id=%0d flags=%b res=%h expected id=%0d flags=%b res=%h",
                                     cyc, rsp_id, rsp_flags, rsp_result, exp_id, exp_v[67:64], exp_v[63:0]); end
          outst = 1'b0;
        end
      end else if (outst && cyc >= acc_cyc + 2) begin
        n_tests++; n_fail++;
        $display("FAIL rnd_late[cyc%0d]: got rsp_valid=0 expected 1 (accepted at %0d)", cyc, acc_cyc);
        outst = 1'b0;
      end
      exp_rdy = '0; g = 0; found = 1'b0;
      if (free && (|req_valid)) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && req_valid[(last + k) % NREQ]) begin
            g = (last + k) % NREQ; found = 1'b1;
          end
        end
        exp_rdy[g] = 1'b1;
      end
      n_tests++;
      if (req_ready !== exp_rdy)
        begin n_fail++; $display("FAIL rnd_grant[cyc%0d]: got req_ready=%b expected %b (valid=%b)", cyc, req_ready, exp_rdy, req_valid); end
      if (found) begin
        exp_id  = IDW'(g);
        exp_v   = alu_model(req_a[g*WIDTH +: WIDTH], req_b[g*WIDTH +: WIDTH], req_ctrl[g*2 +: 2]);
        outst   = 1'b1;
        acc_cyc = cyc;
        last    = g;
        acc[g]  = 1'b1;
      end
    end
    n_tests++;
    if (outst || req_valid != '0)
      begin n_fail++; $display("FAIL rnd_drain: got outstanding=%b valid=%b expected both idle", outst, req_valid); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_all_valid();
    test_backpressure();
    test_reset_midop();
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
